indec_stream: RTL and testbench
===============================

INDEC_STREAM -- requirements
Module: indec_stream

Interface
REQ-001 SHALL have parameter STAGES, default 4, number of trigger stages decoded (legal 1..4).
REQ-002 SHALL have parameter TMO_CYC, default 100000, idle clock cycles before an incomplete long command is dropped.
REQ-003 SHALL have clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst_in  input  1  asynchronous, active-low reset.
REQ-005 SHALL have stb_i  input  1  byte-valid strobe from UART receiver, one cycle per byte, back-to-back allowed.
REQ-006 SHALL have dat_i  input  8  received byte, valid when stb_i=1.
REQ-007 SHALL have cmd_o  output  32  assembled long-command payload, little-endian (first payload byte = cmd_o[7:0]).
REQ-008 SHALL have stg_o  output  STG_W  stage index of last mask/value/config command, STG_W = max(1, clog2(STAGES)).
REQ-009 SHALL have single-cycle pulse outputs, each 1 bit: sft_rst_o, arm_o, id_o, rd_meta_o, fin_now_o, rd_inp_o, arm_adv_o, xon_o, xoff_o, set_div_o, set_cnt_o, set_flgs_o, set_adv_cfg_o, set_adv_dat_o, set_mask_o, set_val_o, set_cfg_o.
REQ-010 SHALL have err_o  output  1  single-cycle pulse on unknown opcode, illegal stage or timeout.
REQ-011 SHALL have busy_o  output  1  high while a long command is being assembled.

Function
REQ-012 SHALL implement FSM IDLE -> PAYLOAD -> IDLE; byte counter 0..3 in PAYLOAD.
REQ-013 IDLE, stb_i with dat_i[7]=0: short command; corresponding pulse asserted exactly the cycle after the strobe; stay IDLE.
REQ-014 Short opcodes: 0x00 sft_rst, 0x01 arm, 0x02 id, 0x04 rd_meta, 0x05 fin_now, 0x06 rd_inp, 0x0F arm_adv, 0x11 xon, 0x13 xoff; any other short opcode -> err_o only.
REQ-015 IDLE, stb_i with dat_i[7]=1: latch opcode, clear counter, go PAYLOAD, busy_o=1 from next cycle.
REQ-016 PAYLOAD: each stb_i shifts dat_i into cmd_o byte lane [counter]; all bytes including 0x00 are data, never short commands.
REQ-017 On the 4th payload strobe: go IDLE, busy_o=0, cmd_o holds full word, decoded pulse asserted the following cycle together with stable cmd_o.
REQ-018 Long opcodes: 0x80 set_div, 0x81 set_cnt, 0x82 set_flgs, 0x9E set_adv_cfg, 0x9F set_adv_dat; 0xC0|s<<2 set_mask, 0xC1|s<<2 set_val, 0xC2|s<<2 set_cfg, stage s = opcode[3:2].
REQ-019 Stage s >= STAGES, or unknown long opcode: payload consumed fully, then err_o only; stg_o unchanged.
REQ-020 stg_o updates only on a legal stage command, same cycle as its pulse.
REQ-021 At most one decode pulse (incl. err_o) SHALL be high in any cycle.
REQ-022 stb_i in the pulse cycle SHALL be accepted normally (zero dead cycles).
REQ-023 cmd_o SHALL not change outside PAYLOAD byte strobes.

Reset
REQ-024 rst_in=0 SHALL immediately force IDLE, counter 0, timeout counter 0, cmd_o=0, stg_o=0, all pulses, err_o and busy_o 0, including mid-payload.
REQ-025 sft_rst_o SHALL NOT reset this block itself.

Configuration
REQ-026 Macro LOGIP_CMD_TIMEOUT_EN defined: timeout counter cleared on every stb_i in PAYLOAD, incremented otherwise; reaching TMO_CYC idle cycles -> IDLE, partial payload discarded, err_o pulse, no command pulse.
REQ-027 Macro undefined: no timeout counter; PAYLOAD waits indefinitely; TMO_CYC ignored.

Structure
REQ-028 Opcode constants, FSM state enum and STG_W function SHALL reside in package indec_pkg.
REQ-029 Timeout counter SHALL be sub-module indec_tmo, instantiated only under LOGIP_CMD_TIMEOUT_EN.

Verification
REQ-030 Bytes 0x01 -> arm_o pulse one cycle after strobe, no other pulse, busy_o stays 0.
REQ-031 Bytes 0x80,0x78,0x56,0x34,0x12 back-to-back -> set_div_o pulse with cmd_o=0x12345678; busy_o high for exactly 4 cycles.
REQ-032 STAGES=2, bytes 0xC4,0xFF,0,0,0 -> set_mask_o, stg_o=1; bytes 0xC8,... -> err_o only, stg_o stays 1.
REQ-033 Bytes 0x82,0x00,0x00,0x00,0x00 -> set_flgs_o with cmd_o=0, no sft_rst_o.
REQ-034 TMO_CYC=16, macro on: 0x81,0xAA then 16 idle cycles -> err_o, IDLE; next 0x02 -> id_o.
REQ-035 rst_in low after 2 payload bytes -> all outputs 0 asynchronously; after release 0x11 -> xon_o.

Source files
------------

// File: rtl/indec_pkg.sv
// Shared opcodes, pulse indices, FSM state and stage-width helper for indec_stream.
package indec_pkg;

  typedef enum logic {ST_IDLE, ST_PAYLOAD} state_e;

  localparam int NPLS = 17;
  localparam int P_SFT_RST     = 0;
  localparam int P_ARM         = 1;
  localparam int P_ID          = 2;
  localparam int P_RD_META     = 3;
  localparam int P_FIN_NOW     = 4;
  localparam int P_RD_INP      = 5;
  localparam int P_ARM_ADV     = 6;
  localparam int P_XON         = 7;
  localparam int P_XOFF        = 8;
  localparam int P_SET_DIV     = 9;
  localparam int P_SET_CNT     = 10;
  localparam int P_SET_FLGS    = 11;
  localparam int P_SET_ADV_CFG = 12;
  localparam int P_SET_ADV_DAT = 13;
  localparam int P_SET_MASK    = 14;
  localparam int P_SET_VAL     = 15;
  localparam int P_SET_CFG     = 16;

  localparam logic [7:0] OP_SFT_RST     = 8'h00;
  localparam logic [7:0] OP_ARM         = 8'h01;
  localparam logic [7:0] OP_ID          = 8'h02;
  localparam logic [7:0] OP_RD_META     = 8'h04;
  localparam logic [7:0] OP_FIN_NOW     = 8'h05;
  localparam logic [7:0] OP_RD_INP      = 8'h06;
  localparam logic [7:0] OP_ARM_ADV     = 8'h0F;
  localparam logic [7:0] OP_XON         = 8'h11;
  localparam logic [7:0] OP_XOFF        = 8'h13;
  localparam logic [7:0] OP_SET_DIV     = 8'h80;
  localparam logic [7:0] OP_SET_CNT     = 8'h81;
  localparam logic [7:0] OP_SET_FLGS    = 8'h82;
  localparam logic [7:0] OP_SET_ADV_CFG = 8'h9E;
  localparam logic [7:0] OP_SET_ADV_DAT = 8'h9F;
  localparam logic [3:0] OP_STG_HI      = 4'hC;
  localparam logic [1:0] SUB_MASK       = 2'd0;
  localparam logic [1:0] SUB_VAL        = 2'd1;
  localparam logic [1:0] SUB_CFG        = 2'd2;

  function automatic int stg_w(input int stages);
    return (stages > 1) ? $clog2(stages) : 1;
  endfunction

endpackage

// File: rtl/indec_tmo.sv
// Idle-cycle watchdog for long-command assembly; only built with LOGIP_CMD_TIMEOUT_EN.
module indec_tmo #(
  parameter int TMO_CYC = 100000
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic run_i,
  input  logic clr_i,
  output logic exp_o
);

  localparam int CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry fires during the TMO_CYC-th consecutive idle cycle so the FSM leaves on that edge.
  assign exp_o = run_i && !clr_i && (cnt_q == CW'(TMO_CYC - 1));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!run_i || clr_i || exp_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/indec_stream.sv
// UART byte-stream command decoder: short 1-byte commands and 5-byte long commands.
// Optional idle timeout on partial long commands: define LOGIP_CMD_TIMEOUT_EN.
module indec_stream
  import indec_pkg::*;
#(
  parameter  int STAGES  = 4,
  parameter  int TMO_CYC = 100000,
  localparam int STG_W   = stg_w(STAGES)
) (
  input  logic             clk_i,
  input  logic             rst_in,
  input  logic             stb_i,
  input  logic [7:0]       dat_i,
  output logic [31:0]      cmd_o,
  output logic [STG_W-1:0] stg_o,
  output logic             sft_rst_o,
  output logic             arm_o,
  output logic             id_o,
  output logic             rd_meta_o,
  output logic             fin_now_o,
  output logic             rd_inp_o,
  output logic             arm_adv_o,
  output logic             xon_o,
  output logic             xoff_o,
  output logic             set_div_o,
  output logic             set_cnt_o,
  output logic             set_flgs_o,
  output logic             set_adv_cfg_o,
  output logic             set_adv_dat_o,
  output logic             set_mask_o,
  output logic             set_val_o,
  output logic             set_cfg_o,
  output logic             err_o,
  output logic             busy_o
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        op_q, op_d;
  logic [31:0]       cmd_q, cmd_d;
  logic [STG_W-1:0]  stg_q, stg_d;
  logic [NPLS-1:0]   pls_q, pls_d;
  logic              err_q, err_d;
  logic              tmo_exp;

`ifdef LOGIP_CMD_TIMEOUT_EN
  indec_tmo #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk_i (clk_i),
    .rst_in(rst_in),
    .run_i (state_q == ST_PAYLOAD),
    .clr_i (stb_i),
    .exp_o (tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    cmd_d   = cmd_q;
    stg_d   = stg_q;
    pls_d   = '0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (stb_i) begin
        if (dat_i[7]) begin
          op_d    = dat_i;
          cnt_d   = 2'd0;
          state_d = ST_PAYLOAD;
        end else begin
          case (dat_i)
            OP_SFT_RST: pls_d[P_SFT_RST] = 1'b1;
            OP_ARM:     pls_d[P_ARM]     = 1'b1;
            OP_ID:      pls_d[P_ID]      = 1'b1;
            OP_RD_META: pls_d[P_RD_META] = 1'b1;
            OP_FIN_NOW: pls_d[P_FIN_NOW] = 1'b1;
            OP_RD_INP:  pls_d[P_RD_INP]  = 1'b1;
            OP_ARM_ADV: pls_d[P_ARM_ADV] = 1'b1;
            OP_XON:     pls_d[P_XON]     = 1'b1;
            OP_XOFF:    pls_d[P_XOFF]    = 1'b1;
            default:    err_d            = 1'b1;
          endcase
        end
      end
      ST_PAYLOAD: if (stb_i) begin
        cmd_d[{cnt_q, 3'b000} +: 8] = dat_i;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = ST_IDLE;
          // Stage opcodes are 0xC0..0xCF: stage in [3:2], sub-command in [1:0].
          if (op_q[7:4] == OP_STG_HI) begin
            if (int'(op_q[3:2]) < STAGES && op_q[1:0] != 2'b11) begin
              stg_d = STG_W'(op_q[3:2]);
              case (op_q[1:0])
                SUB_MASK: pls_d[P_SET_MASK] = 1'b1;
                SUB_VAL:  pls_d[P_SET_VAL]  = 1'b1;
                default:  pls_d[P_SET_CFG]  = 1'b1;
              endcase
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (op_q)
              OP_SET_DIV:     pls_d[P_SET_DIV]     = 1'b1;
              OP_SET_CNT:     pls_d[P_SET_CNT]     = 1'b1;
              OP_SET_FLGS:    pls_d[P_SET_FLGS]    = 1'b1;
              OP_SET_ADV_CFG: pls_d[P_SET_ADV_CFG] = 1'b1;
              OP_SET_ADV_DAT: pls_d[P_SET_ADV_DAT] = 1'b1;
              default:        err_d                = 1'b1;
            endcase
          end
        end
      end else if (tmo_exp) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      cmd_q   <= '0;
      stg_q   <= '0;
      pls_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      cmd_q   <= cmd_d;
      stg_q   <= stg_d;
      pls_q   <= pls_d;
      err_q   <= err_d;
    end
  end

  assign cmd_o         = cmd_q;
  assign stg_o         = stg_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q == ST_PAYLOAD);
  assign sft_rst_o     = pls_q[P_SFT_RST];
  assign arm_o         = pls_q[P_ARM];
  assign id_o          = pls_q[P_ID];
  assign rd_meta_o     = pls_q[P_RD_META];
  assign fin_now_o     = pls_q[P_FIN_NOW];
  assign rd_inp_o      = pls_q[P_RD_INP];
  assign arm_adv_o     = pls_q[P_ARM_ADV];
  assign xon_o         = pls_q[P_XON];
  assign xoff_o        = pls_q[P_XOFF];
  assign set_div_o     = pls_q[P_SET_DIV];
  assign set_cnt_o     = pls_q[P_SET_CNT];
  assign set_flgs_o    = pls_q[P_SET_FLGS];
  assign set_adv_cfg_o = pls_q[P_SET_ADV_CFG];
  assign set_adv_dat_o = pls_q[P_SET_ADV_DAT];
  assign set_mask_o    = pls_q[P_SET_MASK];
  assign set_val_o     = pls_q[P_SET_VAL];
  assign set_cfg_o     = pls_q[P_SET_CFG];

endmodule

// File: tb/tb_indec_stream.sv
// Self-checking bench for indec_stream: vector table plus scoreboard of expected pulses.
module tb_indec_stream;

  localparam int STAGES  = 2;
  localparam int TMO_CYC = 16;

  // Pulse bit positions as assembled below (bit 0 = sft_rst ... bit 16 = set_cfg).
  localparam int SFT = 0, ARM = 1, ID = 2, RDM = 3, FIN = 4, RDI = 5, ARA = 6, XON = 7, XOF = 8;
  localparam int DIV = 9, CNT = 10, FLG = 11, ACF = 12, ADT = 13, MSK = 14, VAL = 15, CFG = 16;
  localparam int ERR = -1;

  logic        clk_i = 1'b0;
  logic        rst_in;
  logic        stb_i;
  logic [7:0]  dat_i;
  logic [31:0] cmd_o;
  logic [0:0]  stg_o;
  logic sft_rst_o, arm_o, id_o, rd_meta_o, fin_now_o, rd_inp_o, arm_adv_o, xon_o, xoff_o;
  logic set_div_o, set_cnt_o, set_flgs_o, set_adv_cfg_o, set_adv_dat_o, set_mask_o, set_val_o;
  logic set_cfg_o, err_o, busy_o;
  logic [16:0] pls;

  indec_stream #(.STAGES(STAGES), .TMO_CYC(TMO_CYC)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .stb_i(stb_i), .dat_i(dat_i),
    .cmd_o(cmd_o), .stg_o(stg_o),
    .sft_rst_o(sft_rst_o), .arm_o(arm_o), .id_o(id_o), .rd_meta_o(rd_meta_o),
    .fin_now_o(fin_now_o), .rd_inp_o(rd_inp_o), .arm_adv_o(arm_adv_o), .xon_o(xon_o),
    .xoff_o(xoff_o), .set_div_o(set_div_o), .set_cnt_o(set_cnt_o), .set_flgs_o(set_flgs_o),
    .set_adv_cfg_o(set_adv_cfg_o), .set_adv_dat_o(set_adv_dat_o), .set_mask_o(set_mask_o),
    .set_val_o(set_val_o), .set_cfg_o(set_cfg_o), .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  assign pls = {set_cfg_o, set_val_o, set_mask_o, set_adv_dat_o, set_adv_cfg_o, set_flgs_o,
                set_cnt_o, set_div_o, xoff_o, xon_o, arm_adv_o, rd_inp_o, fin_now_o,
                rd_meta_o, id_o, arm_o, sft_rst_o};

  typedef struct {
    logic [39:0] b;      // first byte in [39:32]
    int          n;
    int          p;
    logic [31:0] cmd;
    logic        stg;
  } vec_t;

  typedef struct {
    int          due;
    logic [16:0] pls;
    logic        err;
    logic [31:0] cmd;
    logic        stg;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every pulse (or err) must match the head entry on exactly its due cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (busy_o) busy_cnt++;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missed_pulse due %0d now %0d want pls %0h err %0b", e.due, cyc, e.pls, e.err);
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check($sformatf("decode@%0d pls/err/cmd/stg", cyc),
            {13'd0, pls, err_o, cmd_o, stg_o}, {13'd0, e.pls, e.err, e.cmd, e.stg});
    end else if (pls != '0 || err_o) begin
      check($sformatf("unexpected_pulse@%0d", cyc), {46'd0, pls, err_o}, 64'd0);
    end
  end

  task automatic drive(input logic [7:0] b);
    @(negedge clk_i);
    stb_i = 1'b1;
    dat_i = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk_i);
      stb_i = 1'b0;
      dat_i = 8'h00;
    end
  endtask

  task automatic expect_at(input int lat, input int p, input logic [31:0] c, input logic s);
    exp_t e;
    e.due = cyc + lat;
    e.pls = (p < 0) ? 17'd0 : (17'd1 << p);
    e.err = (p < 0);
    e.cmd = c;
    e.stg = s;
    sb.push_back(e);
  endtask

  task automatic add(input logic [39:0] b, input int n, input int p, input logic [31:0] c,
                     input logic s);
    vec_t v;
    v.b = b; v.n = n; v.p = p; v.cmd = c; v.stg = s;
    tbl.push_back(v);
  endtask

  initial begin
    int b0;
    logic [39:0] bb;
    rst_in = 1'b0;
    stb_i  = 1'b0;
    dat_i  = 8'h00;

    // Sequential expectations: cmd_o/stg_o carry over from the previous entry.
    add(40'h00_00000000, 1, SFT, 32'h12345678, 1'b0);
    add(40'h82_00000000, 5, FLG, 32'h00000000, 1'b0);
    add(40'hC4_FF000000, 5, MSK, 32'h000000FF, 1'b1);
    add(40'hC8_11223344, 5, ERR, 32'h44332211, 1'b1);
    add(40'h03_00000000, 1, ERR, 32'h44332211, 1'b1);
    add(40'hC1_AABBCCDD, 5, VAL, 32'hDDCCBBAA, 1'b0);
    add(40'h9E_01020304, 5, ACF, 32'h04030201, 1'b0);
    add(40'h9F_EFBEADDE, 5, ADT, 32'hDEADBEEF, 1'b0);
    add(40'h85_00000000, 5, ERR, 32'h00000000, 1'b0);
    add(40'hC6_05060708, 5, CFG, 32'h08070605, 1'b1);
    add(40'hC3_01010101, 5, ERR, 32'h01010101, 1'b1);
    add(40'h02_00000000, 1, ID,  32'h01010101, 1'b1);
    add(40'h04_00000000, 1, RDM, 32'h01010101, 1'b1);
    add(40'h05_00000000, 1, FIN, 32'h01010101, 1'b1);
    add(40'h06_00000000, 1, RDI, 32'h01010101, 1'b1);
    add(40'h0F_00000000, 1, ARA, 32'h01010101, 1'b1);
    add(40'h13_00000000, 1, XOF, 32'h01010101, 1'b1);
    add(40'h7F_00000000, 1, ERR, 32'h01010101, 1'b1);
    add(40'h81_10000000, 5, CNT, 32'h00000010, 1'b1);
    add(40'h11_00000000, 1, XON, 32'h00000010, 1'b1);

    repeat (3) @(negedge clk_i);
    check("reset_state", {pls, err_o, busy_o, cmd_o, stg_o}, 64'd0);
    @(negedge clk_i);
    rst_in = 1'b1;
    idle(2);

    // Short command: pulse one cycle after strobe, busy never rises.
    b0 = busy_cnt;
    drive(8'h01); expect_at(1, ARM, 32'h0, 1'b0);
    idle(3);
    check("short_busy_cycles", 64'(busy_cnt - b0), 64'd0);

    // Back-to-back long command: busy for exactly four cycles.
    b0 = busy_cnt;
    drive(8'h80); drive(8'h78); drive(8'h56); drive(8'h34); drive(8'h12);
    expect_at(1, DIV, 32'h12345678, 1'b0);
    idle(3);
    check("long_busy_cycles", 64'(busy_cnt - b0), 64'd4);

    // Table: entries run back-to-back, with a one-cycle gap after every odd entry.
    for (int i = 0; i < tbl.size(); i++) begin
      bb = tbl[i].b;
      for (int j = 0; j < tbl[i].n; j++) drive(bb[39 - 8*j -: 8]);
      expect_at(1, tbl[i].p, tbl[i].cmd, tbl[i].stg);
      if (i % 2 == 1) idle(1);
    end
    idle(4);
    check("after_table_busy", {63'd0, busy_o}, 64'd0);

    // Asynchronous reset mid-payload.
    drive(8'h80); drive(8'h11); drive(8'h22);
    @(negedge clk_i);
    stb_i = 1'b0;
    #2 rst_in = 1'b0;
    #1 check("async_reset_outputs", {pls, err_o, busy_o, cmd_o, stg_o}, 64'd0);
    @(negedge clk_i);
    rst_in = 1'b1;
    drive(8'h11); expect_at(1, XON, 32'h0, 1'b0);
    idle(3);

`ifdef LOGIP_CMD_TIMEOUT_EN
    // 16 idle cycles after the last payload byte drop the command with err_o.
    drive(8'h81); drive(8'hAA); expect_at(TMO_CYC + 1, ERR, 32'h000000AA, 1'b0);
    idle(TMO_CYC + 4);
    check("timeout_busy", {63'd0, busy_o}, 64'd0);
    drive(8'h02); expect_at(1, ID, 32'h000000AA, 1'b0);
    idle(3);
`else
    // Without the timeout the partial command waits indefinitely, then completes.
    drive(8'h81); drive(8'hAA);
    idle(TMO_CYC + 4);
    check("no_timeout_busy", {63'd0, busy_o}, 64'd1);
    drive(8'hBB); drive(8'hCC); drive(8'hDD); expect_at(1, CNT, 32'hDDCCBBAA, 1'b0);
    idle(3);
`endif

    idle(4);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle %0d", cyc);
    $fatal(1);
  end

endmodule
